// File: rtl/fetch_issue_ctrl_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and fetch/issue state encodings.
// Pure declarations; no logic.
package cpu_defs;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_JUMP = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int RD_MSB  = 4;
  localparam int RD_LSB  = 3;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 1;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_issue_ctrl_decode.sv
// Combinational instruction decoder; every output is forced to 0 unless en (ISSUE) is high.
// Zero latency, no handshake.
module instr_decode
  import cpu_defs::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [7:0]        ir,
  input  logic              en,
  output logic              jumpSelect,
  output logic [ADDR_W-1:0] address,
  output logic [2:0]        dec_op,
  output logic [1:0]        dec_rd,
  output logic [1:0]        dec_rs,
  output logic [2:0]        dec_imm,
  output logic              illegal,
  output logic              is_halt
);

  logic [2:0] w_op;

  assign w_op       = ir[OP_MSB:OP_LSB];
  assign jumpSelect = en && (w_op == OP_JUMP);
  assign address    = en ? ir[ADDR_W-1:0] : '0;
  assign dec_op     = en ? w_op : 3'd0;
  assign dec_rd     = en ? ir[RD_MSB:RD_LSB] : 2'd0;
  assign dec_rs     = en ? ir[RS_MSB:RS_LSB] : 2'd0;
  assign dec_imm    = en ? ir[IMM_MSB:IMM_LSB] : 3'd0;
  assign illegal    = en && (w_op == OP_NOP);
  assign is_halt    = en && (w_op == OP_HALT);

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue stage owning the PC; fetches over req/valid, issues over valid/ready, min 2 cycles/instr.
// Stalls in FETCH without imem_valid and holds ISSUE outputs stable without dec_ready.
module fetch_issue_ctrl
  import cpu_defs::*;
#(
  parameter int              PC_W     = 8,
  parameter int              ADDR_W   = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [PC_W-1:0]   pc_current,
  input  logic [PC_W-1:0]   pc_next,
  output logic              jumpSelect,
  output logic [ADDR_W-1:0] address,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [7:0]        imem_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [2:0]        dec_op,
  output logic [1:0]        dec_rd,
  output logic [1:0]        dec_rs,
  output logic [2:0]        dec_imm,
  output logic              illegal,
  output logic              halted,
  output logic [7:0]        retire_cnt
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [7:0]      r_retire;
  logic            w_load_ir;
  logic            w_retire;
  logic            w_is_halt;
  logic            w_in_issue;

  assign w_in_issue = (r_state == ST_ISSUE);

  instr_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .ir         (r_ir),
    .en         (w_in_issue),
    .jumpSelect (jumpSelect),
    .address    (address),
    .dec_op     (dec_op),
    .dec_rd     (dec_rd),
    .dec_rs     (dec_rs),
    .dec_imm    (dec_imm),
    .illegal    (illegal),
    .is_halt    (w_is_halt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= 8'd0;
      r_retire <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_ir) begin
        r_ir <= imem_data;
      end
      if (w_retire) begin
        r_retire <= r_retire + 8'd1;
        // HALT retires but leaves the PC pointing at itself.
        if (!w_is_halt) begin
          r_pc <= pc_next;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_ir   = 1'b0;
    w_retire    = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (imem_valid) begin
          w_load_ir   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dec_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = w_is_halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // The request is masked while reset is held so every output reads 0 during reset.
  assign imem_req   = (r_state == ST_FETCH) && !RST;
  assign imem_addr  = r_pc;
  assign dec_valid  = w_in_issue;
  assign halted     = (r_state == ST_HALT);
  assign pc_current = r_pc;
  assign retire_cnt = r_retire;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Bench for fetch_issue_ctrl with an inline pc_inc model and a cycle-level reference model.
module tb_fetch_issue_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] pc_current;
  logic [7:0] pc_next;
  logic       jumpSelect;
  logic [4:0] address;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid = 1'b0;
  logic [7:0] imem_data = 8'd0;
  logic       dec_valid;
  logic       dec_ready = 1'b0;
  logic [2:0] dec_op;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs;
  logic [2:0] dec_imm;
  logic       illegal;
  logic       halted;
  logic [7:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  fetch_issue_ctrl #(
    .PC_W     (8),
    .ADDR_W   (5),
    .RESET_PC (8'd0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pc_current (pc_current),
    .pc_next    (pc_next),
    .jumpSelect (jumpSelect),
    .address    (address),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_op     (dec_op),
    .dec_rd     (dec_rd),
    .dec_rs     (dec_rs),
    .dec_imm    (dec_imm),
    .illegal    (illegal),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  always #5 CLK = ~CLK;

  // pc_inc: jump target zero-extended, otherwise increment with 8-bit wrap.
  assign pc_next = jumpSelect ? {3'b000, address} : pc_current + 8'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: waiting for an instruction, holding one for issue, or stopped.
  localparam int M_WAIT = 0;
  localparam int M_HOLD = 1;
  localparam int M_STOP = 2;
  int         m_mode  = M_WAIT;
  logic [7:0] m_pc    = 8'd0;
  logic [7:0] m_ir    = 8'd0;
  logic [7:0] m_cnt   = 8'd0;
  bit         started = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_mode  = M_WAIT;
      m_pc    = 8'd0;
      m_ir    = 8'd0;
      m_cnt   = 8'd0;
      started = 1'b1;
    end else if (m_mode == M_WAIT && imem_valid) begin
      m_ir   = imem_data;
      m_mode = M_HOLD;
    end else if (m_mode == M_HOLD && dec_ready) begin
      m_cnt = m_cnt + 8'd1;
      if (m_ir[7:5] == 3'd7) begin
        m_mode = M_STOP;
      end else begin
        m_pc   = (m_ir[7:5] == 3'd3) ? {3'b000, m_ir[4:0]} : m_pc + 8'd1;
        m_mode = M_WAIT;
      end
    end
  end

  logic        e_hold;
  logic [27:0] e_vec;
  logic [27:0] a_vec;

  always @(negedge CLK) begin
    if (started) begin
      e_hold = (m_mode == M_HOLD);
      e_vec = {(m_mode == M_WAIT) && !RST, e_hold, e_hold && (m_ir[7:5] == 3'd3),
               e_hold ? m_ir[4:0] : 5'd0, e_hold ? m_ir[7:5] : 3'd0,
               e_hold ? m_ir[4:3] : 2'd0, e_hold ? m_ir[2:1] : 2'd0,
               e_hold ? m_ir[2:0] : 3'd0, e_hold && (m_ir[7:5] == 3'd0),
               m_mode == M_STOP, m_pc};
      a_vec = {imem_req, dec_valid, jumpSelect, address, dec_op, dec_rd, dec_rs,
               dec_imm, illegal, halted, imem_addr};
      chk("model_pc", {24'd0, pc_current}, {24'd0, m_pc});
      chk("model_retire", {24'd0, retire_cnt}, {24'd0, m_cnt});
      chk("model_ctrl", {4'd0, a_vec}, {4'd0, e_vec});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RST = 1'b1;
    step();
    chk("rst_pc", {24'd0, pc_current}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dvld", {31'd0, dec_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retire", {24'd0, retire_cnt}, 32'd0);
    RST = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);

    // ADD back-to-back
    imem_data = 8'b100_01_10_0; imem_valid = 1'b1; dec_ready = 1'b1;
    step();
    chk("add_dvld", {31'd0, dec_valid}, 32'd1);
    chk("add_op", {29'd0, dec_op}, 32'd4);
    chk("add_rd", {30'd0, dec_rd}, 32'd1);
    chk("add_rs", {30'd0, dec_rs}, 32'd2);
    chk("add_jump", {31'd0, jumpSelect}, 32'd0);
    step();
    chk("add_pc", {24'd0, pc_current}, 32'd1);
    chk("add_retire", {24'd0, retire_cnt}, 32'd1);
    repeat (6) step();
    chk("pc_four", {24'd0, pc_current}, 32'd4);

    // JUMP to 16
    imem_data = 8'b011_10000; dec_ready = 1'b0;
    step();
    chk("jmp_sel", {31'd0, jumpSelect}, 32'd1);
    chk("jmp_addr", {27'd0, address}, 32'd16);
    dec_ready = 1'b1;
    step();
    chk("jmp_pc", {24'd0, pc_current}, 32'd16);
    chk("jmp_retire", {24'd0, retire_cnt}, 32'd5);

    // fetch stall
    imem_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_dvld", {31'd0, dec_valid}, 32'd0);
      chk("stall_pc", {24'd0, pc_current}, 32'd16);
    end
    imem_data = 8'b100_01_10_0; imem_valid = 1'b1; dec_ready = 1'b0;
    step();
    chk("stall_issue", {31'd0, dec_valid}, 32'd1);
    imem_valid = 1'b0;

    // issue backpressure
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_dvld", {31'd0, dec_valid}, 32'd1);
      chk("bp_op", {29'd0, dec_op}, 32'd4);
      chk("bp_addr", {27'd0, address}, 32'h0C);
      chk("bp_jump", {31'd0, jumpSelect}, 32'd0);
      chk("bp_pc", {24'd0, pc_current}, 32'd16);
    end
    dec_ready = 1'b1;
    step();
    chk("bp_release_pc", {24'd0, pc_current}, 32'd17);
    dec_ready = 1'b0;
    step();
    chk("bp_once_pc", {24'd0, pc_current}, 32'd17);
    chk("bp_once_retire", {24'd0, retire_cnt}, 32'd6);

    // jump to 7, then HALT
    imem_data = 8'b011_00111; imem_valid = 1'b1; dec_ready = 1'b1;
    step(); step();
    chk("to7_pc", {24'd0, pc_current}, 32'd7);
    imem_data = 8'b111_00000;
    step(); step();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", {24'd0, pc_current}, 32'd7);
    chk("halt_retire", {24'd0, retire_cnt}, 32'd8);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_hold_pc", {24'd0, pc_current}, 32'd7);
      chk("halt_hold_dvld", {31'd0, dec_valid}, 32'd0);
    end
    RST = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    chk("unhalt_pc", {24'd0, pc_current}, 32'd0);
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_req", {31'd0, imem_req}, 32'd1);
    chk("unhalt_retire", {24'd0, retire_cnt}, 32'd0);

    // asynchronous reset mid-ISSUE
    imem_data = 8'b100_01_10_0; imem_valid = 1'b1; dec_ready = 1'b1;
    step(); step();
    chk("pre_async_retire", {24'd0, retire_cnt}, 32'd1);
    imem_data = 8'b011_00011; dec_ready = 1'b0;
    step();
    chk("pre_async_jump", {31'd0, jumpSelect}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_dvld", {31'd0, dec_valid}, 32'd0);
    chk("async_jump", {31'd0, jumpSelect}, 32'd0);
    chk("async_retire", {24'd0, retire_cnt}, 32'd0);
    chk("async_pc", {24'd0, pc_current}, 32'd0);
    #2;
    RST = 1'b0;

    // 256 NOPs: counter and PC both wrap
    imem_data = 8'h00; imem_valid = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      step();
      if (i % 2 == 0) begin
        chk("nop_illegal", {31'd0, illegal}, 32'd1);
        chk("nop_dvld", {31'd0, dec_valid}, 32'd1);
      end
      if (i == 509) begin
        chk("nop_retire_255", {24'd0, retire_cnt}, 32'd255);
      end
    end
    chk("nop_retire_wrap", {24'd0, retire_cnt}, 32'd0);
    chk("nop_pc_wrap", {24'd0, pc_current}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_issue_ctrl.md
Name: fetch_issue_ctrl

Overview:
- Fetch/issue stage that owns the program counter register and sits directly upstream of pc_inc.
- Drives pc_inc's current, jumpSelect and address inputs, and consumes its next output as the next-PC value.
- Fetches 8-bit instructions from instruction memory over a req/valid handshake, decodes the opcode, and presents decoded fields downstream over a valid/ready handshake.
- Advances the PC once per retired instruction.

Parameters:
- PC_W, 8, program counter and instruction-memory address width.
- ADDR_W, 5, jump target width; equals instruction bits [4:0].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- pc_current  out  PC_W  registered PC; drives pc_inc current.
- pc_next  in  PC_W  pc_inc next output; combinational function of pc_current, jumpSelect and address.
- jumpSelect  out  1  1 when the instruction held in ISSUE is JUMP (opcode 011).
- address  out  ADDR_W  ir[4:0] in ISSUE; 0 otherwise.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  equals pc_current.
- imem_valid  in  1  instruction data valid.
- imem_data  in  8  instruction word.
- dec_valid  out  1  decoded instruction available.
- dec_ready  in  1  downstream accepts the decoded instruction.
- dec_op  out  3  ir[7:5].
- dec_rd  out  2  ir[4:3].
- dec_rs  out  2  ir[2:1].
- dec_imm  out  3  ir[2:0], zero-extended by the consumer.
- illegal  out  1  opcode 000 (NOP) in ISSUE; informational only.
- halted  out  1  core stopped.
- retire_cnt  out  8  retired-instruction count.

Behaviour:
- Opcodes: 000 NOP, 001 LW, 010 SW, 011 JUMP, 100 ADD, 101 ADDI, 110 SUB, 111 HALT.

Reset:
- RST asserted at any time, including mid-fetch or mid-issue, immediately clears everything:
  - pc_current = RESET_PC, ir = 0, state = FETCH, retire_cnt = 0.
  - All outputs read 0, except imem_req, which reads 1 once RST deasserts (FETCH state).

State machine (states FETCH, ISSUE, HALT; outputs decoded from state):
- FETCH:
  - imem_req = 1, imem_addr = pc_current, dec_valid = 0, jumpSelect = 0, address = 0.
  - Edge with imem_valid = 1: ir <= imem_data, go to ISSUE.
  - imem_valid = 0: stay; imem_req stays high.
- ISSUE:
  - imem_req = 0, dec_valid = 1.
  - jumpSelect = (ir[7:5] == 011); address = ir[4:0].
  - dec_* fields driven from ir.
  - Edge with dec_ready = 1:
    - pc_current <= pc_next; retire_cnt <= retire_cnt + 1, wrapping 255 -> 0.
    - Next state is FETCH, or HALT if the opcode is 111.
    - HALT: pc_current is NOT updated; retire_cnt IS incremented.
  - dec_ready = 0: hold all outputs stable.
- HALT:
  - halted = 1; all requests and valids are 0.
  - Exit only via RST.

Handshake and arithmetic rules:
- imem_valid is ignored outside FETCH.
- dec_ready is ignored outside ISSUE.
- Minimum 2 cycles per instruction: one FETCH cycle (valid in the same cycle) plus one ISSUE cycle (ready in the same cycle).
- PC wrap: if pc_next is 8'hFF + 1 = 0 (pc_inc truncates), accept 0; no overflow flag.
- JUMP target is zero-extended by pc_inc. This block never computes PC arithmetic itself.
- illegal = 1 only for opcode 000 in ISSUE. NOP still retires and advances the PC normally.

Decomposition:
- Shared package cpu_defs:
  - Opcode localparams OP_NOP..OP_HALT.
  - Field bit positions.
  - State encodings ST_FETCH = 2'd0, ST_ISSUE = 2'd1, ST_HALT = 2'd2.
- Sub-module instr_decode: combinational, ir -> jumpSelect, address, dec_op, dec_rd, dec_rs, dec_imm, illegal, is_halt.
  - Instantiated once and gated by ISSUE state.
- pc_inc is instantiated beside this block at the top level, not inside it.

Test Plan:
1. Reset then imem_data = 8'b100_01_10_0 (ADD) with imem_valid and dec_ready held 1 -> after 2 cycles pc_current = 1, dec_op = 100, dec_rd = 01, dec_rs = 10, jumpSelect = 0, retire_cnt = 1.
2. pc_current = 4, fetch 8'b011_10000 (JUMP) -> in ISSUE jumpSelect = 1, address = 5'b10000; after dec_ready, pc_current = 16 (8'b00010000).
3. Hold imem_valid = 0 for 5 cycles in FETCH -> imem_req stays 1, dec_valid = 0, PC unchanged; imem_valid = 1 on the 6th cycle -> ISSUE next cycle.
4. dec_ready = 0 for 3 cycles in ISSUE -> dec_*, jumpSelect and address stable, PC unchanged; dec_ready = 1 -> PC advances exactly once.
5. Fetch 8'b111_00000 (HALT) at pc = 7 -> halted = 1, pc_current stays 7, imem_req = 0 indefinitely; RST pulse -> pc_current = 0, FETCH.
6. Assert RST asynchronously mid-ISSUE (between edges) -> dec_valid, jumpSelect and retire_cnt drop to 0 before the next CLK edge; run 256 NOPs -> retire_cnt wraps to 0, illegal = 1 during each ISSUE.
